// File: rtl/program_counter_stack_if.sv
// Control/bus-side signal bundle for the program counter with return stack.
// The control block is the master (drives strobes and the jump target);
// the program counter is the slave (returns pc, bus drive and stack status).
interface program_counter_stack_if #(
  parameter int ADDR_W      = 4,
  parameter int STACK_DEPTH = 4
) ();

  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

  logic               cp;
  logic               lp;
  logic               ep;
  logic               call;
  logic               ret;
  logic [ADDR_W-1:0]  load_addr;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  bus_out;
  logic               bus_oe;
  logic [DEPTH_W-1:0] depth;
  logic               stack_full;
  logic               stack_empty;
  logic               stack_err;

  modport master (
    output cp, lp, ep, call, ret, load_addr,
    input  pc, bus_out, bus_oe, depth, stack_full, stack_empty, stack_err
  );

  modport slave (
    input  cp, lp, ep, call, ret, load_addr,
    output pc, bus_out, bus_oe, depth, stack_full, stack_empty, stack_err
  );

endinterface

// File: rtl/program_counter_stack.sv
// Program counter with count/load/output-enable controls and a hardware
// return-address stack for CALL/RET. One action per clock edge, chosen by
// fixed priority ret > call > lp > cp > hold. Illegal pushes/pops are
// ignored and latch a sticky error flag that only reset clears.
module program_counter_stack #(
  parameter int              ADDR_W      = 4,
  parameter int              STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  program_counter_stack_if.slave pcs
);

  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_W-1:0]  pc_q;
  logic [ADDR_W-1:0]  stack_q [STACK_DEPTH];
  logic [DEPTH_W-1:0] depth_q;
  logic               err_q;

  logic               is_empty;
  logic               is_full;
  logic [ADDR_W-1:0]  pc_inc;
  logic [IDX_W-1:0]   push_idx;
  logic [IDX_W-1:0]   pop_idx;

  logic do_pop;
  logic do_push;
  logic do_load;
  logic do_count;
  logic bad_op;

  assign is_empty = (depth_q == '0);
  assign is_full  = (depth_q == DEPTH_W'(STACK_DEPTH));
  // Return address wraps naturally with the ADDR_W-bit sum.
  assign pc_inc   = pc_q + ADDR_W'(1);
  // push_idx is only used when not full, pop_idx only when not empty,
  // so both always land inside the array.
  assign push_idx = IDX_W'(depth_q);
  assign pop_idx  = IDX_W'(depth_q - DEPTH_W'(1));

  // Priority decode of the strobes into exactly one action per edge.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    do_pop   = 1'b0;
    do_push  = 1'b0;
    do_load  = 1'b0;
    do_count = 1'b0;
    bad_op   = 1'b0;
    if (pcs.ret) begin
      if (is_empty) bad_op = 1'b1;
      else          do_pop = 1'b1;
    end else if (pcs.call) begin
      if (is_full) bad_op  = 1'b1;
      else         do_push = 1'b1;
    end else if (pcs.lp) begin
      do_load = 1'b1;
    end else if (pcs.cp) begin
      do_count = 1'b1;
    end
  end

  // PC, stack pointer and sticky error register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      pc_q    <= RESET_ADDR;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (do_pop)                pc_q <= stack_q[pop_idx];
      else if (do_push || do_load) pc_q <= pcs.load_addr;
      else if (do_count)         pc_q <= pc_inc;

      if (do_pop)       depth_q <= depth_q - DEPTH_W'(1);
      else if (do_push) depth_q <= depth_q + DEPTH_W'(1);

      if (bad_op) err_q <= 1'b1;
    end
  end

  // Return-address storage; a pop leaves the popped entry untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the stack array is reset explicitly because its contents must
    // read as zero immediately after reset, which rules out a RAM macro.
    if (!rst_n) begin
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else if (do_push) begin
      stack_q[push_idx] <= pc_inc;
    end
  end

  assign pcs.pc          = pc_q;
  assign pcs.bus_out     = pcs.ep ? pc_q : '0;
  assign pcs.bus_oe      = pcs.ep;
  assign pcs.depth       = depth_q;
  assign pcs.stack_full  = is_full;
  assign pcs.stack_empty = is_empty;
  assign pcs.stack_err   = err_q;

endmodule

// File: doc/program_counter_stack.md
Name: program_counter_stack

Overview:
Parametrised successor to the 4-bit program counter in the 8-bit CPU. It keeps the existing count/load/enable controls (cp, lp, ep), generalises the address width, and adds a hardware return-address stack for CALL/RET. It also adds full/empty/error status. It sits between the control block and the bus: the control block drives the strobes, and the top level muxes bus_out onto the bus when bus_oe is high. There is no internal tri-state.

Parameters:
ADDR_W, 4, program-counter and address width in bits (1..16)
STACK_DEPTH, 4, number of return-address entries (1..16)
RESET_ADDR, 0, PC value after reset (ADDR_W bits)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
cp  input  1  count enable: PC increments at the clock edge
lp  input  1  load enable: PC <= load_addr
ep  input  1  output enable: drive PC onto bus_out
call  input  1  push PC+1 onto the stack, then PC <= load_addr
ret  input  1  PC <= top of stack, then pop
load_addr  input  ADDR_W  jump/call target (bus bits [ADDR_W-1:0])
pc  output  ADDR_W  current PC, always visible
bus_out  output  ADDR_W  pc when ep=1, else 0
bus_oe  output  1  equals ep
depth  output  $clog2(STACK_DEPTH+1)  number of valid stack entries
stack_full  output  1  depth == STACK_DEPTH
stack_empty  output  1  depth == 0
stack_err  output  1  sticky: illegal push or pop attempted

Behaviour:
- Reset is asynchronous and active-low: clk, rst_n.
- On reset assertion, immediately:
  - pc = RESET_ADDR, depth = 0, stack_err = 0
  - all stack entries = 0
  - stack_empty = 1, stack_full = 0
  - bus_out = 0 unless ep is high (bus_out tracks ep combinationally)
- Reset release takes effect at the first rising edge after rst_n goes high. There is no synchroniser; the top level handles that.
- bus_out and bus_oe are combinational from ep and pc. Zero latency.
- All state updates on the rising clk edge. Exactly one action per edge, chosen by fixed priority: ret > call > lp > cp > hold. Lower-priority strobes asserted in the same cycle are ignored.
- ret with depth > 0:
  - pc <= stack[depth-1]; depth <= depth-1
  - the popped entry is left unchanged
- ret with depth == 0: pc, depth and stack unchanged; stack_err <= 1.
- call with depth < STACK_DEPTH:
  - stack[depth] <= (pc+1) mod 2^ADDR_W
  - depth <= depth+1; pc <= load_addr
- call with depth == STACK_DEPTH: no push and no jump (pc unchanged); stack_err <= 1.
- lp: pc <= load_addr. The stack is untouched.
- cp: pc <= (pc+1) mod 2^ADDR_W. Wraps from 2^ADDR_W-1 to 0 silently; no flag.
- stack_err is cleared only by reset. Once set it does not block later legal operations.
- stack_full and stack_empty are combinational from depth.
- Return address on call wraps, e.g. pc = 15 with ADDR_W=4 pushes 0.
- ep does not interact with state changes. Driving the PC onto the bus and loading it in the same cycle is legal: bus_out shows the pre-edge value.
- Reset asserted mid-operation, including within the same cycle as a call/ret, overrides all strobes. The stack empties immediately.
- A recommended structure is a register-array stack indexed by depth. No inferred latches.

Test Plan:
1. Reset and count (ADDR_W=4, RESET_ADDR=0): release reset, cp=1 for 17 cycles -> pc steps 0..15, 0, 1. stack_empty=1, stack_err=0 throughout.
2. Output enable: pc=5, ep=0 -> bus_out=0, bus_oe=0. ep=1 -> bus_out=5, bus_oe=1 in the same cycle, with no edge needed.
3. Nested call/return (STACK_DEPTH=2):
   - at pc=3, call load_addr=9 -> pc=9, depth=1
   - call load_addr=12 -> pc=12, depth=2, stack_full=1
   - ret -> pc=10; ret -> pc=4, stack_empty=1
4. Overflow and underflow (STACK_DEPTH=2, depth=2, pc=7):
   - call load_addr=1 -> pc stays 7, depth 2, stack_err=1
   - two rets then a third ret -> third ret leaves pc unchanged
   - stack_err stays 1 until rst_n pulses low
5. Priority:
   - ret=call=lp=cp=1 with depth=1, top=6 -> pc=6, depth=0
   - lp=cp=1, load_addr=2 -> pc=2, not pc+1
   - call at pc=15 -> pushed value 0
6. Asynchronous reset mid-stack: depth=2, pc=11, drop rst_n between clock edges -> pc=0, depth=0, stack_err=0 immediately, before the next edge. A subsequent ret sets stack_err=1.
